sqrt: RTL and testbench

SQRT -- requirements
Module: sqrt

---
 rtl/sqrt.sv | 149 ++++++++++++++
 tb/tb_sqrt.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sqrt.sv
`default_nettype none
// ============================================================================
//  Module   : sqrt
//  Purpose  : Sequential 32-bit integer square root. A restoring
//             digit-by-digit algorithm retires one result bit per cycle, so a
//             non-negative operand completes 17 edges after start is sampled.
//             A negative operand is flagged invalid and completes after 1 edge.
//  Ports    : clk        - system clock, rising-edge active
//             rst        - asynchronous reset, active low
//             start      - computation request, level-sampled while idle
//             initial_nr - radicand, two's-complement signed
//             ready      - result valid / handshake acknowledge
//             result     - floor(sqrt(initial_nr))
//             Cflag      - inexact flag, remainder nonzero
//             Oflag      - invalid-operand flag, negative radicand
//  Revision : 1.0 - initial release
// ============================================================================
module sqrt (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] initial_nr,
   output logic        ready,
   output logic [15:0] result,
   output logic        Cflag,
   output logic        Oflag
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic [31:0] r_radicand;
   logic [4:0]  r_count;
   logic [15:0] r_root;
   logic [17:0] r_rem;
   logic [15:0] r_result;
   logic        r_cflag;
   logic        r_oflag;

   logic [17:0] w_rem_shift;
   logic [17:0] w_trial;
   logic        w_fits;
   logic [17:0] w_rem_next;
   logic [15:0] w_root_next;

   // One restoring iteration: bring down the next radicand bit pair (MSB pair
   // first, taken from the top of the shifting radicand register) and try
   // subtracting 4*root+1. The remainder never exceeds 2*root, so 18 bits hold
   // the shifted value without loss.
   assign w_rem_shift = (r_rem << 2) | {16'd0, r_radicand[31:30]};
   assign w_trial     = {r_root, 2'b01};
   assign w_fits      = (w_rem_shift >= w_trial);
   assign w_rem_next  = w_fits ? (w_rem_shift - w_trial) : w_rem_shift;
   assign w_root_next = {r_root[14:0], w_fits};

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next_state = initial_nr[31] ? DONE : CALC;
            end
         end
         CALC: begin
            if (r_count == 5'd1) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            if (!start) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Datapath and result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_radicand <= 32'd0;
         r_count    <= 5'd0;
         r_root     <= 16'd0;
         r_rem      <= 18'd0;
         r_result   <= 16'd0;
         r_cflag    <= 1'b0;
         r_oflag    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_radicand <= initial_nr;
                  if (initial_nr[31]) begin
                     r_result <= 16'd0;
                     r_cflag  <= 1'b0;
                     r_oflag  <= 1'b1;
                  end else begin
                     r_count <= 5'd16;
                     r_root  <= 16'd0;
                     r_rem   <= 18'd0;
                     r_oflag <= 1'b0;
                  end
               end
            end
            CALC: begin
               r_radicand <= r_radicand << 2;
               r_count    <= r_count - 5'd1;
               r_root     <= w_root_next;
               r_rem      <= w_rem_next;
               // Final iteration publishes straight from the iteration logic
               // so ready and the result appear on the same edge.
               if (r_count == 5'd1) begin
                  r_result <= w_root_next;
                  r_cflag  <= (w_rem_next != 18'd0);
               end
            end
            default: begin
               // DONE: outputs held; leaving DONE keeps them for the next
               // idle period.
            end
         endcase
      end
   end

   // Ready follows the state directly so an asynchronous reset drops it
   // together with the state register.
   assign ready  = (r_state == DONE);
   assign result = r_result;
   assign Cflag  = r_cflag;
   assign Oflag  = r_oflag;

endmodule
`default_nettype wire

// File: tb/tb_sqrt.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sqrt
//  Purpose  : Self-checking bench for sqrt: directed vector table, random
//             operands against an arithmetic reference, and hand-written
//             handshake / reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sqrt;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] initial_nr;
   logic        ready;
   logic [15:0] result;
   logic        Cflag;
   logic        Oflag;

   int checks;
   int errors;

   sqrt dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .initial_nr (initial_nr),
      .ready      (ready),
      .result     (result),
      .Cflag      (Cflag),
      .Oflag      (Oflag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] op;
      logic [15:0] res;
      logic        c;
      logic        o;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Reference: largest r with r*r <= n, found by plain 64-bit arithmetic.
   function automatic logic [15:0] ref_root(input logic [31:0] n);
      longint v;
      longint lo;
      longint hi;
      longint mid;
      v  = longint'(n);
      lo = 0;
      hi = 65535;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= v) lo = mid;
         else hi = mid - 1;
      end
      return lo[15:0];
   endfunction

   // Full transaction: start, wait for ready, check latency and outputs,
   // drop start, check ready falls and outputs are retained.
   task automatic run_op(input logic [31:0] op, input logic [15:0] exp_res,
                         input logic exp_c, input logic exp_o, input string tag);
      int lat;
      int exp_lat;
      exp_lat = op[31] ? 1 : 17;
      @(negedge clk);
      initial_nr = op;
      start      = 1'b1;
      lat        = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!ready && lat < 40);
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " result"},  {16'd0, result}, {16'd0, exp_res});
      check({tag, " Cflag"},   {31'd0, Cflag},  {31'd0, exp_c});
      check({tag, " Oflag"},   {31'd0, Oflag},  {31'd0, exp_o});
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check({tag, " ready drop"}, {31'd0, ready}, 32'd0);
      check({tag, " result held"}, {16'd0, result}, {16'd0, exp_res});
   endtask

   vec_t vecs[10];

   initial begin
      logic [31:0] rop;
      logic [15:0] rr;
      int          lat;
      checks     = 0;
      errors     = 0;
      rst        = 1'b0;
      start      = 1'b0;
      initial_nr = 32'd0;

      vecs[0] = '{32'hFFFF_FFC0, 16'd0,     1'b0, 1'b1};
      vecs[1] = '{32'd64,        16'd8,     1'b0, 1'b0};
      vecs[2] = '{32'd65,        16'd8,     1'b1, 1'b0};
      vecs[3] = '{32'd0,         16'd0,     1'b0, 1'b0};
      vecs[4] = '{32'h7FFF_FFFF, 16'd46340, 1'b1, 1'b0};
      vecs[5] = '{32'd1,         16'd1,     1'b0, 1'b0};
      vecs[6] = '{32'h8000_0000, 16'd0,     1'b0, 1'b1};
      vecs[7] = '{32'd15,        16'd3,     1'b1, 1'b0};
      vecs[8] = '{32'h3FFF_0001, 16'd32767, 1'b0, 1'b0};
      vecs[9] = '{32'hFFFF_FFFF, 16'd0,     1'b0, 1'b1};

      // Reset state
      #12;
      check("reset ready",  {31'd0, ready}, 32'd0);
      check("reset result", {16'd0, result}, 32'd0);
      check("reset Cflag",  {31'd0, Cflag}, 32'd0);
      check("reset Oflag",  {31'd0, Oflag}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Directed table
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].op, vecs[i].res, vecs[i].c, vecs[i].o, $sformatf("vec%0d", i));
      end

      // Random operands against the arithmetic reference
      for (int i = 0; i < 24; i++) begin
         rop = $urandom;
         if (i % 3 == 0) rop[31] = 1'b0;
         if (i % 4 == 1) rop = rop >> $urandom_range(2, 28);
         rr = rop[31] ? 16'd0 : ref_root(rop);
         run_op(rop, rr, (!rop[31]) && (longint'(rr) * longint'(rr) != longint'(rop)),
                rop[31], $sformatf("rnd%0d", i));
      end

      // Handshake with 144: operand and start disturbed mid-CALC, start held in DONE
      @(negedge clk);
      initial_nr = 32'd144;
      start      = 1'b1;
      lat        = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 5) begin
            initial_nr = 32'hFFFF_0000;
            start      = 1'b0;
         end
         if (lat == 7) begin
            initial_nr = 32'd99;
            start      = 1'b1;
         end
      end while (!ready && lat < 40);
      check("hs latency", lat, 17);
      check("hs result", {16'd0, result}, 32'd12);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("hs hold ready %0d", k), {31'd0, ready}, 32'd1);
         check($sformatf("hs hold result %0d", k), {16'd0, result}, 32'd12);
      end
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check("hs ready drop", {31'd0, ready}, 32'd0);

      // Reset mid-CALC aborts and clears outputs without a clock edge
      @(negedge clk);
      initial_nr = 32'h7FFF_FFFF;
      start      = 1'b1;
      for (int k = 0; k < 8; k++) @(posedge clk);
      #2;
      start = 1'b0;
      rst   = 1'b0;
      #1;
      check("rst ready",  {31'd0, ready}, 32'd0);
      check("rst result", {16'd0, result}, 32'd0);
      check("rst Cflag",  {31'd0, Cflag}, 32'd0);
      check("rst Oflag",  {31'd0, Oflag}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
      end
      #1;
      check("post-rst no stale ready", {31'd0, ready}, 32'd0);
      run_op(32'd225, 16'd15, 1'b0, 1'b0, "after rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
